// File: rtl/e_port_alloc_ctrl_if.sv
// ---------------------------------------------------------------------------
// e_port_alloc_ctrl_if
// Bundle between the four input buffers (N, S, W, L), the east link credit
// return and the east-port allocator.
//
// Signals
//   <p>_req_i            head flit valid in input buffer <p>
//   <p>_nexthop_addr_i   head flit next-hop code (000 N, 001 S, 010 W, 011 E, 100 L)
//   <p>_tail_i           head flit is the packet tail
//   e_credit_return_i    downstream east buffer freed one slot
//   e_alloc_to_cs_o      crossbar select (winner code, 111 when idle)
//   e_alloc_grant_<p>_o  registered one-hot grant
//   <p>_pop_o            dequeue head flit of buffer <p> this cycle
//   e_flit_valid_o       a flit crosses to east this cycle
//   e_credits_o          current credit count
//   e_credit_err_o       sticky credit overflow flag
//   e_timeout_o          watchdog release pulse
//
// Modports
//   master : buffers / link side (drives requests, sees grants and pops)
//   slave  : allocator side
// ---------------------------------------------------------------------------
interface e_port_alloc_ctrl_if #(
  parameter int CREDIT_W = 3
);
  logic                n_req_i;
  logic                s_req_i;
  logic                w_req_i;
  logic                l_req_i;
  logic [2:0]          n_nexthop_addr_i;
  logic [2:0]          s_nexthop_addr_i;
  logic [2:0]          w_nexthop_addr_i;
  logic [2:0]          l_nexthop_addr_i;
  logic                n_tail_i;
  logic                s_tail_i;
  logic                w_tail_i;
  logic                l_tail_i;
  logic                e_credit_return_i;

  logic [2:0]          e_alloc_to_cs_o;
  logic                e_alloc_grant_n_o;
  logic                e_alloc_grant_s_o;
  logic                e_alloc_grant_w_o;
  logic                e_alloc_grant_l_o;
  logic                n_pop_o;
  logic                s_pop_o;
  logic                w_pop_o;
  logic                l_pop_o;
  logic                e_flit_valid_o;
  logic [CREDIT_W-1:0] e_credits_o;
  logic                e_credit_err_o;
  logic                e_timeout_o;

  modport master (
    output n_req_i, s_req_i, w_req_i, l_req_i,
    output n_nexthop_addr_i, s_nexthop_addr_i, w_nexthop_addr_i, l_nexthop_addr_i,
    output n_tail_i, s_tail_i, w_tail_i, l_tail_i,
    output e_credit_return_i,
    input  e_alloc_to_cs_o,
    input  e_alloc_grant_n_o, e_alloc_grant_s_o, e_alloc_grant_w_o, e_alloc_grant_l_o,
    input  n_pop_o, s_pop_o, w_pop_o, l_pop_o,
    input  e_flit_valid_o, e_credits_o, e_credit_err_o, e_timeout_o
  );

  modport slave (
    input  n_req_i, s_req_i, w_req_i, l_req_i,
    input  n_nexthop_addr_i, s_nexthop_addr_i, w_nexthop_addr_i, l_nexthop_addr_i,
    input  n_tail_i, s_tail_i, w_tail_i, l_tail_i,
    input  e_credit_return_i,
    output e_alloc_to_cs_o,
    output e_alloc_grant_n_o, e_alloc_grant_s_o, e_alloc_grant_w_o, e_alloc_grant_l_o,
    output n_pop_o, s_pop_o, w_pop_o, l_pop_o,
    output e_flit_valid_o, e_credits_o, e_credit_err_o, e_timeout_o
  );
endinterface

// File: rtl/e_port_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// e_port_alloc_ctrl
// Packet-level allocator for the router's east output port. Picks one of the
// N/S/W/L input buffers whose head flit targets east (round-robin between
// packets), holds the grant until the tail flit leaves, drives crossbar
// select and buffer pops, and tracks downstream credits so the east link
// never overflows.
//
// Ports
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    e_port_alloc_ctrl_if.slave (requests, credits, grants, pops)
//
// Parameters
//   MAX_CREDITS     downstream east buffer depth (credit reset value/ceiling)
//   CREDIT_W        credit counter width
//   TIMEOUT_CYCLES  stall limit of the optional watchdog
//
// Build option
//   E_ALLOC_TIMEOUT_EN  adds a bubble watchdog that releases a stuck grant;
//                       without it the grant is held indefinitely and
//                       e_timeout_o is tied low.
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; arbitrate among eligible requesters this cycle
// BUSY  | grant held; pop flits of the winner while credits allow
// ---------------------------------------------------------------------------
module e_port_alloc_ctrl #(
  parameter int MAX_CREDITS    = 4,
  parameter int CREDIT_W       = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                 clk,
  input logic                 reset,
  e_port_alloc_ctrl_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [2:0] CS_IDLE = 3'b111;
  localparam logic [2:0] NH_EAST = 3'b011;

  localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(MAX_CREDITS);
  localparam logic [CREDIT_W-1:0] CRED_ONE = CREDIT_W'(1);

  // Elaboration-time sanity check; the block is pruned for legal values.
  if (MAX_CREDITS < 1 || MAX_CREDITS > (2 ** CREDIT_W) - 1 || TIMEOUT_CYCLES < 1)
  begin : g_param_check
    $error("e_port_alloc_ctrl: CREDIT_W cannot hold MAX_CREDITS or TIMEOUT_CYCLES < 1");
  end

  // Requester index: 0 N, 1 S, 2 W, 3 L (also the round-robin order).
  function automatic logic [2:0] port_code(input logic [1:0] idx);
    logic [2:0] code;
    case (idx)
      2'd0:    code = 3'b000;
      2'd1:    code = 3'b001;
      2'd2:    code = 3'b010;
      default: code = 3'b100;
    endcase
    return code;
  endfunction

  logic [3:0]          req;
  logic [3:0]          tail;
  logic [3:0]          elig;
  logic [2:0]          nexthop [4];

  logic [0:0]          state_q;
  logic [3:0]          grant_q;
  logic [1:0]          win_q;
  logic [1:0]          ptr_q;
  logic [2:0]          cs_q;
  logic [CREDIT_W-1:0] credits_q;
  logic                err_q;

  logic                arb_found;
  logic [1:0]          arb_idx;
  logic [1:0]          cand;
  logic                cur_req;
  logic                cur_tail;
  logic                transfer;
  logic [3:0]          pop_vec;
  logic                credit_ret;
  logic                timeout_fire;

  assign req  = {bus.l_req_i, bus.w_req_i, bus.s_req_i, bus.n_req_i};
  assign tail = {bus.l_tail_i, bus.w_tail_i, bus.s_tail_i, bus.n_tail_i};
  assign nexthop[0] = bus.n_nexthop_addr_i;
  assign nexthop[1] = bus.s_nexthop_addr_i;
  assign nexthop[2] = bus.w_nexthop_addr_i;
  assign nexthop[3] = bus.l_nexthop_addr_i;
  assign credit_ret = bus.e_credit_return_i;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      elig[i] = req[i] && (nexthop[i] == NH_EAST);
    end
  end

  // First eligible requester scanning cyclically from the pointer.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!arb_found && elig[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign cur_req  = req[win_q];
  assign cur_tail = tail[win_q];

  // Pops are gated by reset so nothing leaves a buffer in the reset cycle.
  assign transfer = !reset && (state_q == ST_BUSY) && cur_req && (credits_q != '0);
  assign pop_vec  = transfer ? (4'b0001 << win_q) : 4'b0000;

`ifdef E_ALLOC_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_q;
  logic               timeout_q;
  logic               bubble;

  // Only empty-buffer bubbles count; credit stalls are the link's problem.
  assign bubble       = !reset && (state_q == ST_BUSY) && !cur_req;
  assign timeout_fire = bubble && (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_fire;
      if (state_q == ST_IDLE || transfer || timeout_fire) begin
        stall_q <= '0;
      end else if (bubble) begin
        stall_q <= stall_q + STALL_W'(1);
      end
    end
  end

  assign bus.e_timeout_o = timeout_q;
`else
  assign timeout_fire    = 1'b0;
  assign bus.e_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= 4'b0000;
      win_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cs_q    <= CS_IDLE;
    end else if (state_q == ST_IDLE) begin
      if (arb_found) begin
        state_q <= ST_BUSY;
        grant_q <= 4'b0001 << arb_idx;
        win_q   <= arb_idx;
        cs_q    <= port_code(arb_idx);
      end
    end else begin
      if ((transfer && cur_tail) || timeout_fire) begin
        state_q <= ST_IDLE;
        grant_q <= 4'b0000;
        cs_q    <= CS_IDLE;
        ptr_q   <= win_q + 2'd1;
      end
    end
  end

  // Pop and return together cancel; a return at the ceiling is an overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q <= CRED_MAX;
      err_q     <= 1'b0;
    end else if (transfer && !credit_ret) begin
      credits_q <= credits_q - CRED_ONE;
    end else if (!transfer && credit_ret) begin
      if (credits_q == CRED_MAX) begin
        err_q <= 1'b1;
      end else begin
        credits_q <= credits_q + CRED_ONE;
      end
    end
  end

  assign bus.e_alloc_to_cs_o   = cs_q;
  assign bus.e_alloc_grant_n_o = grant_q[0];
  assign bus.e_alloc_grant_s_o = grant_q[1];
  assign bus.e_alloc_grant_w_o = grant_q[2];
  assign bus.e_alloc_grant_l_o = grant_q[3];
  assign bus.n_pop_o           = pop_vec[0];
  assign bus.s_pop_o           = pop_vec[1];
  assign bus.w_pop_o           = pop_vec[2];
  assign bus.l_pop_o           = pop_vec[3];
  assign bus.e_flit_valid_o    = transfer;
  assign bus.e_credits_o       = credits_q;
  assign bus.e_credit_err_o    = err_q;

endmodule

// File: tb/tb_e_port_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_e_port_alloc_ctrl
// Drives packet traffic from four flit sources into the east allocator and
// checks every cycle against a packet-level reference model. Expected
// per-cycle outputs and expected flit transfers are queued by the driver and
// consumed by an independent monitor at the falling edge.
// ---------------------------------------------------------------------------
module tb_e_port_alloc_ctrl;

  localparam int MAXC = 4;
  localparam int CW   = 3;
  localparam int TO   = 16;

  typedef struct {
    logic [2:0] nh;
    logic       tail;
    logic       head;
  } flit_t;

  typedef struct {
    logic [3:0] grant;
    logic [2:0] cs;
    logic [3:0] pop;
    logic       valid;
    int         credits;
    logic       err;
    logic       tout;
  } exp_t;

  logic clk;
  logic reset;

  e_port_alloc_ctrl_if #(.CREDIT_W(CW)) bus ();

  e_port_alloc_ctrl #(
    .MAX_CREDITS   (MAXC),
    .CREDIT_W      (CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  flit_t src [4][$];
  exp_t  cycle_q [$];
  int    xfer_q [$];

  int code_of [4] = '{0, 1, 2, 4};

  // reference model: packet-level allocator state
  int m_busy, m_owner, m_ptr, m_credits, m_err, m_stall, m_tout;

  logic r_hold [4];
  logic r_ret;
  logic r_rst;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_credits = MAXC;
    m_err = 0; m_stall = 0; m_tout = 0;
  endtask

  task automatic add_pkt(input int p, input int len, input logic [2:0] dst);
    flit_t f;
    for (int i = 0; i < len; i++) begin
      f.head = (i == 0);
      f.tail = (i == len - 1);
      f.nh   = (i == 0) ? dst : 3'($urandom_range(0, 4));
      src[p].push_back(f);
    end
  endtask

  task automatic clear_src();
    for (int p = 0; p < 4; p++) src[p].delete();
  endtask

  // One clock cycle: present source heads, predict outputs, advance model.
  task automatic step();
    logic [3:0] req;
    logic [3:0] tl;
    logic [2:0] nh [4];
    exp_t       e;
    bit         xfer;
    int         win;
    int         owner;
    flit_t      f;

    for (int p = 0; p < 4; p++) begin
      req[p] = (src[p].size() > 0) && !r_hold[p];
      nh[p]  = (src[p].size() > 0) ? src[p][0].nh : 3'b000;
      tl[p]  = (src[p].size() > 0) ? src[p][0].tail : 1'b0;
    end
    bus.n_req_i = req[0]; bus.s_req_i = req[1]; bus.w_req_i = req[2]; bus.l_req_i = req[3];
    bus.n_nexthop_addr_i = nh[0]; bus.s_nexthop_addr_i = nh[1];
    bus.w_nexthop_addr_i = nh[2]; bus.l_nexthop_addr_i = nh[3];
    bus.n_tail_i = tl[0]; bus.s_tail_i = tl[1]; bus.w_tail_i = tl[2]; bus.l_tail_i = tl[3];
    bus.e_credit_return_i = r_ret;
    reset = r_rst;

    owner   = m_owner;
    xfer    = !r_rst && (m_busy != 0) && req[owner] && (m_credits > 0);
    e.grant = (m_busy != 0) ? 4'(1 << owner) : 4'b0000;
    e.cs    = (m_busy != 0) ? 3'(code_of[owner]) : 3'b111;
    e.pop   = xfer ? 4'(1 << owner) : 4'b0000;
    e.valid = xfer;
    e.credits = m_credits;
    e.err   = (m_err != 0);
    e.tout  = (m_tout != 0);
    cycle_q.push_back(e);
    if (xfer) xfer_q.push_back(owner);

    if (r_rst) begin
      model_reset();
    end else begin
      if (xfer && !r_ret) m_credits--;
      else if (!xfer && r_ret) begin
        if (m_credits == MAXC) m_err = 1;
        else m_credits++;
      end
      m_tout = 0;
      if (m_busy == 0) begin
        win = -1;
        for (int k = 0; k < 4; k++) begin
          if (win < 0 && req[(m_ptr + k) % 4] && nh[(m_ptr + k) % 4] == 3'b011)
            win = (m_ptr + k) % 4;
        end
        if (win >= 0) begin
          m_busy = 1; m_owner = win; m_stall = 0;
        end
      end else if (xfer) begin
        m_stall = 0;
        if (tl[owner]) begin
          m_busy = 0; m_ptr = (owner + 1) % 4;
        end
      end else if (!req[owner]) begin
`ifdef E_ALLOC_TIMEOUT_EN
        m_stall++;
        if (m_stall == TO) begin
          m_busy = 0; m_ptr = (owner + 1) % 4; m_tout = 1;
        end
`endif
      end
    end

    if (xfer) f = src[owner].pop_front();
    // packets for other outputs leave via other allocators after one look
    for (int p = 0; p < 4; p++) begin
      if (src[p].size() > 0 && src[p][0].head && src[p][0].nh != 3'b011) begin
        f = src[p].pop_front();
        while (!f.tail && src[p].size() > 0) f = src[p].pop_front();
      end
    end

    @(posedge clk);
    #1;
  endtask

  // Monitor
  exp_t       mon_e;
  int         mon_p;
  logic [3:0] mon_g;
  logic [3:0] mon_pop;

  always @(negedge clk) begin
    mon_g   = {bus.e_alloc_grant_l_o, bus.e_alloc_grant_w_o, bus.e_alloc_grant_s_o, bus.e_alloc_grant_n_o};
    mon_pop = {bus.l_pop_o, bus.w_pop_o, bus.s_pop_o, bus.n_pop_o};
    if (cycle_q.size() > 0) begin
      mon_e = cycle_q.pop_front();
      chk("grant",   32'(mon_g), 32'(mon_e.grant));
      chk("cs",      32'(bus.e_alloc_to_cs_o), 32'(mon_e.cs));
      chk("pop",     32'(mon_pop), 32'(mon_e.pop));
      chk("valid",   32'(bus.e_flit_valid_o), 32'(mon_e.valid));
      chk("credits", 32'(bus.e_credits_o), 32'(mon_e.credits));
      chk("err",     32'(bus.e_credit_err_o), 32'(mon_e.err));
      chk("timeout", 32'(bus.e_timeout_o), 32'(mon_e.tout));
      chk("grant_onehot", 32'($countones(mon_g) <= 1), 32'(1));
    end
    if (bus.e_flit_valid_o === 1'b1) begin
      if (xfer_q.size() == 0) begin
        chk("xfer_unexpected", 32'(mon_pop), 32'(0));
      end else begin
        mon_p = xfer_q.pop_front();
        chk("xfer_port", 32'(mon_pop), 32'(1 << mon_p));
        chk("xfer_cs",   32'(bus.e_alloc_to_cs_o), 32'(code_of[mon_p]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    r_rst = 1'b1; r_ret = 1'b0;
    for (int p = 0; p < 4; p++) r_hold[p] = 1'b0;
    reset = 1'b1;
    bus.n_req_i = 0; bus.s_req_i = 0; bus.w_req_i = 0; bus.l_req_i = 0;
    bus.n_nexthop_addr_i = 0; bus.s_nexthop_addr_i = 0;
    bus.w_nexthop_addr_i = 0; bus.l_nexthop_addr_i = 0;
    bus.n_tail_i = 0; bus.s_tail_i = 0; bus.w_tail_i = 0; bus.l_tail_i = 0;
    bus.e_credit_return_i = 0;
    @(posedge clk);
    #1;
    model_reset();

    // 1: S sends a 3-flit packet
    step();
    r_rst = 1'b0;
    add_pkt(1, 3, 3'b011);
    repeat (6) step();

    // 2: N, W, L stream single-flit packets with a credit back every cycle
    r_ret = 1'b1;
    repeat (12) begin
      add_pkt(0, 1, 3'b011); add_pkt(2, 1, 3'b011); add_pkt(3, 1, 3'b011);
      step();
      clear_src();
    end
    r_ret = 1'b0;
    repeat (3) step();

    // 3: 6-flit packet runs dry on credits, then two returns finish it
    clear_src(); r_rst = 1'b1; step(); r_rst = 1'b0;
    add_pkt(2, 6, 3'b011);
    repeat (10) step();
    r_ret = 1'b1; step(); r_ret = 1'b0; step();
    r_ret = 1'b1; step(); r_ret = 1'b0;
    repeat (4) step();

    // 4: return together with pop at 2 credits, then overflow at the ceiling
    clear_src(); r_rst = 1'b1; step(); r_rst = 1'b0;
    add_pkt(0, 8, 3'b011);
    repeat (3) step();
    r_ret = 1'b1; step(); r_ret = 1'b0;
    repeat (4) step();
    r_ret = 1'b1; repeat (14) step(); r_ret = 1'b0;
    repeat (3) step();

    // 5: reset in the middle of an L packet, then N beats L
    clear_src(); r_rst = 1'b1; step(); r_rst = 1'b0;
    add_pkt(3, 6, 3'b011);
    repeat (3) step();
    clear_src(); r_rst = 1'b1; step(); r_rst = 1'b0;
    add_pkt(0, 1, 3'b011); add_pkt(3, 1, 3'b011);
    repeat (5) step();

`ifdef E_ALLOC_TIMEOUT_EN
    // 6: granted W goes silent, watchdog releases, L wins next
    clear_src(); r_rst = 1'b1; step(); r_rst = 1'b0;
    add_pkt(2, 3, 3'b011);
    step();
    r_hold[2] = 1'b1;
    add_pkt(3, 1, 3'b011); add_pkt(0, 1, 3'b011);
    repeat (20) step();
    r_hold[2] = 1'b0;
    r_ret = 1'b1; repeat (8) step(); r_ret = 1'b0;
`endif

    // random traffic
    clear_src(); r_rst = 1'b1; step(); r_rst = 1'b0;
    repeat (3000) begin
      for (int p = 0; p < 4; p++) begin
        if (src[p].size() == 0 && $urandom_range(0, 3) == 0)
          add_pkt(p, $urandom_range(1, 5),
                  ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 4)) : 3'b011);
        r_hold[p] = ($urandom_range(0, 7) == 0);
      end
      if (m_credits < MAXC) r_ret = ($urandom_range(0, 1) == 1);
      else                  r_ret = ($urandom_range(0, 49) == 0);
      r_rst = ($urandom_range(0, 699) == 0);
      if (r_rst) clear_src();
      step();
    end
    r_rst = 1'b0;
    for (int p = 0; p < 4; p++) r_hold[p] = 1'b0;
    r_ret = 1'b1;
    repeat (40) step();
    r_ret = 1'b0;
    step();

    @(negedge clk);
    #1;
    chk("scoreboard_cycles_drained", 32'(cycle_q.size()), 32'(0));
    chk("scoreboard_xfers_drained",  32'(xfer_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
